// File: rtl/sp256k_sram_if.sv
// Access bus for the 16K x 16 single-port RAM: address/data/mask, access strobes,
// power-mode controls and registered read data.
interface sp256k_sram_if;
  logic [13:0] ad;
  logic [15:0] di;
  logic [3:0]  maskwe;
  logic        we;
  logic        cs;
  logic        stdby;
  logic        sleep;
  logic        pwroff_n;
  logic [15:0] dout;

  modport master (
    output ad, di, maskwe, we, cs, stdby, sleep, pwroff_n,
    input  dout
  );

  modport slave (
    input  ad, di, maskwe, we, cs, stdby, sleep, pwroff_n,
    output dout
  );
endinterface

// File: rtl/sp256k_sram.sv
// 16384 x 16 single-port RAM with nibble write mask, registered read port and
// standby/sleep/power-off modes; per-word valid bits make powered-off words read as zero.
module sp256k_sram (
  input  logic         clk,
  input  logic         rst,
  sp256k_sram_if.slave bus
);

  logic [15:0]    mem [0:16383];
  logic [16383:0] valid;
  logic [15:0]    do_q;
  logic [15:0]    bit_mask;
  logic [15:0]    old_word;
  logic           access;
  logic           wr_en;
  logic           rd_en;

  // Mode priority: power-off over sleep over standby over normal.
  assign access = bus.pwroff_n & ~bus.sleep & ~bus.stdby & bus.cs;
  assign wr_en  = access & bus.we & (|bus.maskwe);
  assign rd_en  = access & ~bus.we;

  always_comb begin
    bit_mask = '0;
    for (int n = 0; n < 4; n++) begin
      bit_mask[4*n +: 4] = {4{bus.maskwe[n]}};
    end
  end

  // An invalid word is treated as zero, so a partial write into it leaves the other nibbles at 0.
  assign old_word = valid[bus.ad] ? mem[bus.ad] : 16'h0000;

  always_ff @(posedge clk) begin
    if (!bus.pwroff_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[bus.ad] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[bus.ad] <= (old_word & ~bit_mask) | (bus.di & bit_mask);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_q <= 16'h0000;
    end else if (!bus.pwroff_n || bus.sleep) begin
      do_q <= 16'h0000;
    end else if (rd_en) begin
      do_q <= old_word;
    end
  end

  assign bus.dout = do_q;

endmodule

// File: tb/tb_sp256k_sram.sv
// Bench for sp256k_sram: directed vectors plus randomized traffic against an array model.
module tb_sp256k_sram;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  sp256k_sram_if bus ();

  sp256k_sram dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: each word holds what a read returns (invalid words are simply 0).
  logic [15:0] ref_mem [0:16383];
  logic [15:0] exp_do;

  task automatic model_clear();
    for (int i = 0; i < 16384; i++) ref_mem[i] = 16'h0000;
  endtask

  // Apply one cycle of inputs, clock it, and advance the model.
  task automatic step(input logic cs, input logic we, input logic [13:0] ad,
                      input logic [15:0] di, input logic [3:0] mask,
                      input logic stdby, input logic sleep, input logic pwroff_n);
    logic [15:0] m;
    @(negedge clk);
    bus.cs = cs; bus.we = we; bus.ad = ad; bus.di = di; bus.maskwe = mask;
    bus.stdby = stdby; bus.sleep = sleep; bus.pwroff_n = pwroff_n;
    @(posedge clk);
    #1;
    if (!pwroff_n) begin
      model_clear();
      exp_do = 16'h0000;
    end else if (sleep) begin
      exp_do = 16'h0000;
    end else if (!stdby && cs) begin
      if (we) begin
        m = {{4{mask[3]}}, {4{mask[2]}}, {4{mask[1]}}, {4{mask[0]}}};
        ref_mem[ad] = (ref_mem[ad] & ~m) | (di & m);
      end else begin
        exp_do = ref_mem[ad];
      end
    end
  endtask

  task automatic wr(input logic [13:0] ad, input logic [15:0] di, input logic [3:0] mask);
    step(1'b1, 1'b1, ad, di, mask, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [13:0] ad);
    step(1'b1, 1'b0, ad, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    bus.cs = 0; bus.we = 0; bus.ad = '0; bus.di = '0; bus.maskwe = '0;
    bus.stdby = 0; bus.sleep = 0; bus.pwroff_n = 0;
    model_clear();
    exp_do = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.dout !== 16'h0000) begin
      bad++; $display("FAIL reset_do got=%h want=%h", bus.dout, 16'h0000);
    end
    @(negedge clk);
    rst = 0;
    bus.pwroff_n = 1;
    step(1'b0, 1'b0, 14'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    total++;
    if (bus.dout !== 16'h0000) begin
      bad++; $display("FAIL post_reset_do got=%h want=%h", bus.dout, 16'h0000);
    end
    rd(14'h1234);
    total++;
    if (bus.dout !== 16'h0000) begin
      bad++; $display("FAIL fresh_word_read got=%h want=%h", bus.dout, 16'h0000);
    end
  endtask

  task automatic test_nibble_writes();
    wr(14'h0005, 16'hA5C3, 4'hF);
    rd(14'h0005);
    total++;
    if (bus.dout !== 16'hA5C3) begin
      bad++; $display("FAIL full_write got=%h want=%h", bus.dout, 16'hA5C3);
    end
    wr(14'h0005, 16'h1234, 4'b0011);
    rd(14'h0005);
    total++;
    if (bus.dout !== 16'hA534) begin
      bad++; $display("FAIL mask_low got=%h want=%h", bus.dout, 16'hA534);
    end
    wr(14'h0005, 16'hBEEF, 4'b1100);
    rd(14'h0005);
    total++;
    if (bus.dout !== 16'hBE34) begin
      bad++; $display("FAIL mask_high got=%h want=%h", bus.dout, 16'hBE34);
    end
    wr(14'h0FFF, 16'h7F00, 4'b1100);
    rd(14'h0FFF);
    total++;
    if (bus.dout !== 16'h7F00) begin
      bad++; $display("FAIL byte_lane_fresh got=%h want=%h", bus.dout, 16'h7F00);
    end
    step(1'b0, 1'b0, 14'h0005, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    total++;
    if (bus.dout !== 16'h7F00) begin
      bad++; $display("FAIL cs_low_hold got=%h want=%h", bus.dout, 16'h7F00);
    end
    wr(14'h0007, 16'hFFFF, 4'h0);
    rd(14'h0007);
    total++;
    if (bus.dout !== 16'h0000) begin
      bad++; $display("FAIL mask_zero_write got=%h want=%h", bus.dout, 16'h0000);
    end
  endtask

  task automatic test_low_power();
    rd(14'h0FFF);
    step(1'b1, 1'b0, 14'h0005, 16'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    total++;
    if (bus.dout !== 16'h0000) begin
      bad++; $display("FAIL sleep_do got=%h want=%h", bus.dout, 16'h0000);
    end
    rd(14'h0005);
    total++;
    if (bus.dout !== 16'hBE34) begin
      bad++; $display("FAIL sleep_retain got=%h want=%h", bus.dout, 16'hBE34);
    end
    step(1'b1, 1'b1, 14'h0005, 16'h0000, 4'hF, 1'b1, 1'b0, 1'b1);
    total++;
    if (bus.dout !== 16'hBE34) begin
      bad++; $display("FAIL stdby_hold got=%h want=%h", bus.dout, 16'hBE34);
    end
    rd(14'h0FFF);
    rd(14'h0005);
    total++;
    if (bus.dout !== 16'hBE34) begin
      bad++; $display("FAIL stdby_no_write got=%h want=%h", bus.dout, 16'hBE34);
    end
  endtask

  task automatic test_rst_midread();
    rd(14'h0FFF);
    #2 rst = 1;
    #1;
    total++;
    if (bus.dout !== 16'h0000) begin
      bad++; $display("FAIL async_rst got=%h want=%h", bus.dout, 16'h0000);
    end
    rst = 0;
    exp_do = 16'h0000;
    rd(14'h0FFF);
    total++;
    if (bus.dout !== 16'h7F00) begin
      bad++; $display("FAIL reread_after_rst got=%h want=%h", bus.dout, 16'h7F00);
    end
  endtask

  task automatic test_power_off();
    rd(14'h0005);
    step(1'b0, 1'b0, 14'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.dout !== 16'h0000) begin
      bad++; $display("FAIL pwroff_do got=%h want=%h", bus.dout, 16'h0000);
    end
    rd(14'h0005);
    total++;
    if (bus.dout !== 16'h0000) begin
      bad++; $display("FAIL pwroff_lost got=%h want=%h", bus.dout, 16'h0000);
    end
    wr(14'h0005, 16'h1357, 4'hF);
    rd(14'h0005);
    total++;
    if (bus.dout !== 16'h1357) begin
      bad++; $display("FAIL pwroff_rewrite got=%h want=%h", bus.dout, 16'h1357);
    end
    wr(14'h0006, 16'hFFFF, 4'b0001);
    rd(14'h0006);
    total++;
    if (bus.dout !== 16'h000F) begin
      bad++; $display("FAIL pwroff_partial got=%h want=%h", bus.dout, 16'h000F);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] a;
    logic [15:0] d;
    for (int i = 0; i < 8; i++) begin
      a = 14'($urandom_range(0, 16383));
      d = 16'($urandom);
      wr(a, d, 4'hF);
      rd(a);
      total++;
      if (bus.dout !== d) begin
        bad++; $display("FAIL back_to_back a=%h got=%h want=%h", a, bus.dout, d);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic cs, we, stdby, sleep, pwr;
    logic [13:0] a;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      pwr = (r >= 2);
      sleep = (r >= 2 && r < 7);
      stdby = (r >= 7 && r < 13) || ($urandom_range(0, 19) == 0);
      cs = ($urandom_range(0, 9) != 0);
      we = $urandom_range(0, 1) == 1;
      a = 14'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 14'h3FF0 : 14'h0);
      step(cs, we, a, 16'($urandom), 4'($urandom_range(0, 15)), stdby, sleep, pwr);
      total++;
      if (bus.dout !== exp_do) begin
        bad++; $display("FAIL random_%0d a=%h got=%h want=%h", i, a, bus.dout, exp_do);
      end
    end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_nibble_writes();
        test_low_power();
        test_rst_midread();
        test_power_off();
        test_back_to_back();
        test_random();
      end
      begin
        #200000;
        bad++;
        $display("FAIL timeout got=running want=done");
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
